// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

  localparam logic [1:0] OP_UMUL = 2'b00;
  localparam logic [1:0] OP_SMUL = 2'b01;
  localparam logic [1:0] OP_UDIV = 2'b10;
  localparam logic [1:0] OP_SDIV = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  localparam int FL_N  = 3;
  localparam int FL_Z  = 2;
  localparam int FL_DZ = 1;
  localparam int FL_OV = 0;

endpackage

// File: rtl/mdu_ctrl.sv
// Sequencer for mdu_iter: issue handshake, iteration counter, result strobes.
// state  | meaning
// S_IDLE | ready for issue
// S_RUN  | one datapath iteration per cycle, WIDTH cycles
// S_FIX  | sign fix / special cases, outputs registered
// S_DONE | res_valid pulse
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic flush,
  output logic ready,
  output logic res_valid,
  output logic load,
  output logic step,
  output logic commit
);

  state_t            state, state_nxt;
  logic [CNTW-1:0]   cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (load)
        cnt <= CNTW'(WIDTH);
      else if (step)
        cnt <= cnt - CNTW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    commit    = 1'b0;
    case (state)
      S_IDLE: begin
        // flush outranks start, so a simultaneous pair is not an issue
        if (start && !flush) begin
          load      = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (flush) begin
          state_nxt = S_IDLE;
        end else begin
          step = 1'b1;
          if (cnt == CNTW'(1))
            state_nxt = S_FIX;
        end
      end
      S_FIX: begin
        if (flush) begin
          state_nxt = S_IDLE;
        end else begin
          commit    = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign ready     = (state == S_IDLE);
  assign res_valid = (state == S_DONE);

endmodule

// File: rtl/mdu_iter.sv
// Iterative multiply/divide: shift-add multiply and restoring divide on
// operand magnitudes, with sign correction and special cases applied in FIX.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             ready,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic [3:0]       flags
);

  localparam int CNTW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  logic load, step, commit;

  mdu_ctrl #(.WIDTH(WIDTH), .CNTW(CNTW)) u_ctrl (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .flush     (flush),
    .ready     (ready),
    .res_valid (res_valid),
    .load      (load),
    .step      (step),
    .commit    (commit)
  );

  logic             op_div, op_sgn, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;

  always_comb begin
    op_div = (op == OP_UDIV) || (op == OP_SDIV);
    op_sgn = (op == OP_SMUL) || (op == OP_SDIV);
    sa     = op_sgn & a[WIDTH-1];
    sb     = op_sgn & b[WIDTH-1];
    mag_a  = sa ? -a : a;
    mag_b  = sb ? -b : b;
  end

  // acc_hi:acc_lo is the product (mul) or remainder:dividend/quotient (div)
  logic             div_q, neg_q, neg_r, dz_q, ov_q;
  logic [WIDTH-1:0] a_q, m_q, acc_hi, acc_lo;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic [WIDTH:0]   add_sum, shifted, trial;

  always_comb begin
    add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m_q} : '0);
    shifted = {acc_hi, acc_lo[WIDTH-1]};
    trial   = shifted - {1'b0, m_q};
    if (div_q) begin
      lo_nxt = {acc_lo[WIDTH-2:0], ~trial[WIDTH]};
      hi_nxt = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    end else begin
      hi_nxt = add_sum[WIDTH:1];
      lo_nxt = {add_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;
  logic [3:0]         fix_flags;

  always_comb begin
    prod = {acc_hi, acc_lo};
    if (neg_q)
      prod = -prod;
    quo = acc_lo;
    if (neg_q)
      quo = -acc_lo;
    rem = acc_hi;
    if (neg_r)
      rem = -acc_hi;
    fix_hi    = prod[2*WIDTH-1:WIDTH];
    fix_lo    = prod[WIDTH-1:0];
    fix_flags = '0;
    if (div_q) begin
      fix_hi = rem;
      fix_lo = quo;
      if (dz_q) begin
        fix_hi = a_q;
        fix_lo = '1;
      end else if (ov_q) begin
        fix_hi = '0;
        fix_lo = MIN_VAL;
      end
      fix_flags[FL_N]  = fix_lo[WIDTH-1];
      fix_flags[FL_Z]  = (fix_lo == '0);
      fix_flags[FL_DZ] = dz_q;
      fix_flags[FL_OV] = ov_q;
    end else begin
      fix_flags[FL_N] = fix_hi[WIDTH-1];
      fix_flags[FL_Z] = (prod == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz_q   <= 1'b0;
      ov_q   <= 1'b0;
      a_q    <= '0;
      m_q    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      res_hi <= '0;
      res_lo <= '0;
      flags  <= '0;
    end else begin
      if (load) begin
        div_q  <= op_div;
        neg_q  <= sa ^ sb;
        neg_r  <= sa;
        dz_q   <= op_div && (b == '0);
        ov_q   <= (op == OP_SDIV) && (a == MIN_VAL) && (b == '1);
        a_q    <= a;
        m_q    <= op_div ? mag_b : mag_a;
        acc_hi <= '0;
        acc_lo <= op_div ? mag_a : mag_b;
      end else if (step) begin
        acc_hi <= hi_nxt;
        acc_lo <= lo_nxt;
      end
      if (commit) begin
        res_hi <= fix_hi;
        res_lo <= fix_lo;
        flags  <= fix_flags;
      end
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed and randomized ops against an arithmetic model,
// plus handshake, flush and reset timing; a second 8-bit instance for width scaling.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset, start, flush;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         ready, res_valid;
  logic [W-1:0] res_hi, res_lo;
  logic [3:0]   flags;

  logic         start8, flush8, ready8, valid8;
  logic [1:0]   op8;
  logic [7:0]   a8, b8, hi8, lo8;
  logic [3:0]   flags8;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] last_hi, last_lo;
  logic [3:0]   last_fl;

  mdu_iter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .ready(ready), .res_valid(res_valid), .res_hi(res_hi), .res_lo(res_lo), .flags(flags)
  );

  mdu_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8), .flush(flush8),
    .ready(ready8), .res_valid(valid8), .res_hi(hi8), .res_lo(lo8), .flags(flags8)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the architectural definition.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] x, y,
                                output logic [W-1:0] hi, output logic [W-1:0] lo,
                                output logic [3:0] fl);
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx = $signed(x);
    sy = $signed(y);
    fl = 4'b0000;
    if (o == OP_UMUL || o == OP_SMUL) begin
      if (o == OP_UMUL) p = {32'd0, x} * {32'd0, y};
      else              p = sx * sy;
      hi = p[63:32];
      lo = p[31:0];
      fl[3] = hi[31];
      fl[2] = (p == 64'd0);
    end else begin
      if (y == 0) begin
        lo = 32'hFFFFFFFF;
        hi = x;
        fl[1] = 1'b1;
      end else if (o == OP_UDIV) begin
        lo = x / y;
        hi = x % y;
      end else if (x == 32'h80000000 && y == 32'hFFFFFFFF) begin
        lo = 32'h80000000;
        hi = 32'h0;
        fl[0] = 1'b1;
      end else begin
        q  = sx / sy;
        r  = sx % sy;
        lo = 32'(q);
        hi = 32'(r);
      end
      fl[3] = lo[31];
      fl[2] = (lo == 32'd0);
    end
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 50 && !ready; i++) @(negedge clk);
    check({tag, "_wait_ready"}, ready, 1);
  endtask

  // Issue at k=0; res_valid must appear only at k=W+2 and ready return at k=W+3.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, y,
                        input bit noise, input string tag);
    logic [W-1:0] eh, el, ch, cl;
    logic [3:0]   ef, cf;
    int           vk, vcount, rdy_bad;
    logic         rdy_end;
    model(o, x, y, eh, el, ef);
    wait_ready(tag);
    start = 1'b1; op = o; a = x; b = y;
    vk = -1; vcount = 0; rdy_bad = 0; rdy_end = 1'b0;
    ch = '0; cl = '0; cf = '0;
    for (int k = 1; k <= W + 3; k++) begin
      @(negedge clk);
      if (res_valid) begin
        vcount++;
        if (vk < 0) begin vk = k; ch = res_hi; cl = res_lo; cf = flags; end
      end
      if (k <= W + 2 && ready) rdy_bad++;
      if (k == W + 3) rdy_end = ready;
      start = (noise && k <= W + 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      op = 2'($urandom);
      a  = $urandom;
      b  = $urandom;
    end
    check({tag, "_valid_cycle"}, vk, W + 2);
    check({tag, "_valid_count"}, vcount, 1);
    check({tag, "_ready_low"}, rdy_bad, 0);
    check({tag, "_ready_back"}, rdy_end, 1);
    check({tag, "_hi"}, ch, eh);
    check({tag, "_lo"}, cl, el);
    check({tag, "_flags"}, cf, ef);
    last_hi = eh; last_lo = el; last_fl = ef;
  endtask

  // Flush asserted for one cycle at k=fk after issue.
  task automatic flush_op(input logic [1:0] o, input logic [W-1:0] x, y,
                          input int fk, input string tag);
    logic [W-1:0] eh, el, ch, cl;
    logic [3:0]   ef, cf;
    int           vcount;
    logic         rdy_after;
    model(o, x, y, eh, el, ef);
    wait_ready(tag);
    start = 1'b1; op = o; a = x; b = y;
    vcount = 0; rdy_after = 1'b0;
    ch = '0; cl = '0; cf = '0;
    for (int k = 1; k <= W + 4; k++) begin
      @(negedge clk);
      if (res_valid) begin vcount++; ch = res_hi; cl = res_lo; cf = flags; end
      if (k == fk + 1) rdy_after = ready;
      start = 1'b0;
      flush = (k == fk);
    end
    flush = 1'b0;
    check({tag, "_ready_after"}, rdy_after, 1);
    if (fk <= W + 1) begin
      check({tag, "_no_valid"}, vcount, 0);
      check({tag, "_hi_kept"}, res_hi, last_hi);
      check({tag, "_lo_kept"}, res_lo, last_lo);
      check({tag, "_flags_kept"}, flags, last_fl);
    end else begin
      check({tag, "_valid_count"}, vcount, 1);
      check({tag, "_hi"}, ch, eh);
      check({tag, "_lo"}, cl, el);
      check({tag, "_flags"}, cf, ef);
      last_hi = eh; last_lo = el; last_fl = ef;
    end
  endtask

  initial begin
    int          vcount, vk;
    logic [7:0]  c8hi, c8lo;
    logic [3:0]  c8fl;
    logic [1:0]  ro;

    reset = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
    start8 = 1'b0; flush8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
    last_hi = '0; last_lo = '0; last_fl = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_valid", res_valid, 0);
    check("rst_hi", res_hi, 0);
    check("rst_lo", res_lo, 0);
    check("rst_flags", flags, 0);
    check("rst_ready8", ready8, 1);
    reset = 1'b0;
    @(negedge clk);

    run_op(OP_UMUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "umul_max");
    run_op(OP_SMUL, 32'hFFFFFFFD, 32'd7, 1'b1, "smul_neg");
    run_op(OP_SMUL, 32'd0, 32'h12345678, 1'b0, "smul_zero");
    run_op(OP_SDIV, 32'hFFFFFFF9, 32'd2, 1'b1, "sdiv_neg");
    run_op(OP_UDIV, 32'd100, 32'd7, 1'b0, "udiv_100_7");
    run_op(OP_UDIV, 32'd100, 32'd0, 1'b1, "udiv_dz");
    run_op(OP_SDIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, "sdiv_ov");

    flush_op(OP_UMUL, 32'd1234, 32'd5678, 5, "flush_run");
    flush_op(OP_SDIV, 32'hFFFF0000, 32'd3, W + 1, "flush_fix");
    flush_op(OP_UDIV, 32'd1000, 32'd3, W + 2, "flush_done");

    start = 1'b1; flush = 1'b1; op = OP_UMUL; a = 32'd5; b = 32'd6;
    @(negedge clk);
    check("idle_flush_start", ready, 1);
    start = 1'b0; flush = 1'b0;

    wait_ready("rst_mid");
    start = 1'b1; op = OP_UMUL; a = 32'hDEADBEEF; b = 32'h12345;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", ready, 1);
    check("rst_mid_valid", res_valid, 0);
    check("rst_mid_hi", res_hi, 0);
    check("rst_mid_lo", res_lo, 0);
    check("rst_mid_flags", flags, 0);
    reset = 1'b0;
    last_hi = '0; last_lo = '0; last_fl = '0;
    vcount = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (res_valid) vcount++;
    end
    check("rst_mid_no_valid", vcount, 0);

    for (int i = 0; i < 20; i++) begin
      ro = 2'($urandom_range(0, 3));
      run_op(ro, pick(), pick(), 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end

    start8 = 1'b1; op8 = OP_UMUL; a8 = 8'hFF; b8 = 8'hFF;
    vk = -1; c8hi = '0; c8lo = '0; c8fl = '0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (valid8 && vk < 0) begin vk = k; c8hi = hi8; c8lo = lo8; c8fl = flags8; end
      start8 = 1'b0;
    end
    check("w8_valid_cycle", vk, 10);
    check("w8_hi", c8hi, 8'hFE);
    check("w8_lo", c8lo, 8'h01);
    check("w8_flags", c8fl, 4'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
